// File: rtl/game_sprite_pkg.sv
// Shared types and constants for the sprite display path.
package game_sprite_pkg;

  // Default colour depth of one sprite pixel.
  localparam int SPRITE_RGB_WIDTH = 3;

  // Bitmap value that marks a pixel as see-through.
  localparam int TRANSPARENT = 0;

  // The display path idles until the first frame start, then tracks frames.
  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } sprite_state_t;

endpackage

// File: rtl/game_sprite_rom.sv
// Sprite bitmap lookup: (col,row) -> pixel colour, purely combinational.
// Kept as its own block so a block-RAM version can drop in later.
module game_sprite_rom
  import game_sprite_pkg::*;
#(
  parameter int SPRITE_WIDTH  = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter int RGB_WIDTH     = SPRITE_RGB_WIDTH,
  parameter int COL_W         = 3,
  parameter int ROW_W         = 3,
  parameter logic [SPRITE_WIDTH*SPRITE_HEIGHT*RGB_WIDTH-1:0] BITMAP =
    {(SPRITE_WIDTH*SPRITE_HEIGHT*RGB_WIDTH){1'b1}}
) (
  input  logic [COL_W-1:0]     i_col,
  input  logic [ROW_W-1:0]     i_row,
  output logic [RGB_WIDTH-1:0] o_pix
);

  localparam int NPIX  = SPRITE_WIDTH * SPRITE_HEIGHT;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  logic [RGB_WIDTH-1:0] w_rom [NPIX];
  logic [IDX_W-1:0]     w_idx;

  // Unpack the flat bitmap so each pixel is one table entry.
  for (genvar gi = 0; gi < NPIX; gi++) begin : g_unpack
    assign w_rom[gi] = BITMAP[gi*RGB_WIDTH +: RGB_WIDTH];
  end

  // Row-major pixel index.
  assign w_idx = IDX_W'(int'(i_row) * SPRITE_WIDTH + int'(i_col));
  assign o_pix = w_rom[w_idx];

endmodule

// File: rtl/game_sprite_display.sv
// Per-pixel sprite coverage and colour for the pixel mixer.
// Sprite position/enable are shadowed at frame start so the sprite never
// tears; a two-stage pipeline (range check, then bitmap lookup) gives a
// fixed two-cycle latency. frame_hit reports whether the previous frame
// drew any sprite pixel.
module game_sprite_display
  import game_sprite_pkg::*;
#(
  parameter int SPRITE_WIDTH  = 8,
  parameter int SPRITE_HEIGHT = 8,
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height),
  parameter int RGB_WIDTH     = SPRITE_RGB_WIDTH,
  parameter logic [SPRITE_WIDTH*SPRITE_HEIGHT*RGB_WIDTH-1:0] SPRITE_BITMAP =
    {(SPRITE_WIDTH*SPRITE_HEIGHT*RGB_WIDTH){1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 display_on,
  input  logic [w_x-1:0]       pixel_x,
  input  logic [w_y-1:0]       pixel_y,
  input  logic [w_x-1:0]       sprite_x,
  input  logic [w_y-1:0]       sprite_y,
  input  logic                 sprite_enable,
  output logic                 sprite_within,
  output logic [RGB_WIDTH-1:0] sprite_rgb,
  output logic                 frame_hit
);

  localparam int COL_W = (SPRITE_WIDTH  > 1) ? $clog2(SPRITE_WIDTH)  : 1;
  localparam int ROW_W = (SPRITE_HEIGHT > 1) ? $clog2(SPRITE_HEIGHT) : 1;
  localparam logic signed [w_x:0] LIM_X = SPRITE_WIDTH[w_x:0];
  localparam logic signed [w_y:0] LIM_Y = SPRITE_HEIGHT[w_y:0];

  sprite_state_t r_state;
  sprite_state_t w_state_nxt;
  logic          w_track;

  logic           r_prev00;
  logic [w_x-1:0] r_shadow_x;
  logic [w_y-1:0] r_shadow_y;
  logic           r_shadow_en;
  logic           r_hit_accum;
  logic           r_frame_hit;

  logic             r_vld_p1;
  logic [COL_W-1:0] r_col_p1;
  logic [ROW_W-1:0] r_row_p1;

  logic                 r_within_p2;
  logic [RGB_WIDTH-1:0] r_rgb_p2;

  logic                 w_at00;
  logic                 w_fs;
  logic [w_x-1:0]       w_sx;
  logic [w_y-1:0]       w_sy;
  logic                 w_sen;
  logic signed [w_x:0]  w_dx;
  logic signed [w_y:0]  w_dy;
  logic                 w_in_x;
  logic                 w_in_y;
  logic                 w_hit_p0;
  logic [RGB_WIDTH-1:0] w_pix;
  logic                 w_within_nxt;

  // Frame start is the first cycle the raster sits at (0,0).
  assign w_at00 = (pixel_x == '0) && (pixel_y == '0);
  assign w_fs   = w_at00 && !r_prev00;

  // Remember whether the raster was at (0,0) last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev00 <= 1'b0;
    else     r_prev00 <= w_at00;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_FRAME;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: leave WAIT_FRAME on the first frame start, then stay.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_FRAME: if (w_fs) w_state_nxt = ACTIVE;
      ACTIVE:     w_state_nxt = ACTIVE;
      default:    w_state_nxt = WAIT_FRAME;
    endcase
  end

  // FSM output: pixels are only evaluated while tracking frames.
  always_comb begin
    w_track = (r_state == ACTIVE);
  end

  // Shadow sprite position/enable once per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_x  <= '0;
      r_shadow_y  <= '0;
      r_shadow_en <= 1'b0;
    end else if (w_fs) begin
      r_shadow_x  <= sprite_x;
      r_shadow_y  <= sprite_y;
      r_shadow_en <= sprite_enable;
    end
  end

  // The frame-start pixel already sees the values being sampled.
  assign w_sx  = w_fs ? sprite_x      : r_shadow_x;
  assign w_sy  = w_fs ? sprite_y      : r_shadow_y;
  assign w_sen = w_fs ? sprite_enable : r_shadow_en;

  // Signed offsets: a pixel left of/above the sprite goes negative
  // instead of wrapping into range.
  assign w_dx = $signed({1'b0, pixel_x}) - $signed({1'b0, w_sx});
  assign w_dy = $signed({1'b0, pixel_y}) - $signed({1'b0, w_sy});

  assign w_in_x   = !w_dx[w_x] && (w_dx < LIM_X);
  assign w_in_y   = !w_dy[w_y] && (w_dy < LIM_Y);
  assign w_hit_p0 = w_track && display_on && w_sen && w_in_x && w_in_y;

  // ---- stage 1: range check registered, sprite-local col/row ----
  // Valid bit of stage 1 is the in-rectangle flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= w_hit_p0;
  end

  // Sprite-local coordinates travel alongside the valid bit.
  always_ff @(posedge clk) begin
    r_col_p1 <= w_dx[COL_W-1:0];
    r_row_p1 <= w_dy[ROW_W-1:0];
  end

  game_sprite_rom #(
    .SPRITE_WIDTH (SPRITE_WIDTH),
    .SPRITE_HEIGHT(SPRITE_HEIGHT),
    .RGB_WIDTH    (RGB_WIDTH),
    .COL_W        (COL_W),
    .ROW_W        (ROW_W),
    .BITMAP       (SPRITE_BITMAP)
  ) u_rom (
    .i_col(r_col_p1),
    .i_row(r_row_p1),
    .o_pix(w_pix)
  );

  assign w_within_nxt = r_vld_p1 && (w_pix != RGB_WIDTH'(TRANSPARENT));

  // ---- stage 2: bitmap colour registered, transparent pixels dropped ----
  // Output registers; colour is forced to zero outside the sprite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_within_p2 <= 1'b0;
      r_rgb_p2    <= '0;
    end else begin
      r_within_p2 <= w_within_nxt;
      r_rgb_p2    <= w_within_nxt ? w_pix : '0;
    end
  end

  // Sticky per-frame hit flag, published and cleared at each frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_accum <= 1'b0;
      r_frame_hit <= 1'b0;
    end else if (w_fs) begin
      r_frame_hit <= r_hit_accum;
      r_hit_accum <= 1'b0;
    end else begin
      r_hit_accum <= r_hit_accum | r_within_p2;
    end
  end

  assign sprite_within = r_within_p2;
  assign sprite_rgb    = r_rgb_p2;
  assign frame_hit     = r_frame_hit;

endmodule

// File: tb/tb_game_sprite_display.sv
// Scoreboard bench for game_sprite_display: two instances (solid bitmap and
// a patterned bitmap with transparent pixels) share the same stimulus.
module tb_game_sprite_display;

  localparam int SW = 8;
  localparam int SH = 8;
  localparam int WX = 10;
  localparam int WY = 9;
  localparam int RW = 3;
  localparam int NP = SW * SH;

  // Patterned bitmap: colour (c + 3r) mod 8, so (0,0) is transparent.
  function automatic logic [NP*RW-1:0] make_bmp();
    logic [NP*RW-1:0] v;
    logic [NP*RW-1:0] t;
    v = '0;
    for (int i = 0; i < NP; i++) begin
      t = '0;
      t[RW-1:0] = RW'(((i % SW) + 3 * (i / SW)) % 8);
      v = v | (t << (i * RW));
    end
    return v;
  endfunction

  localparam logic [NP*RW-1:0] BMP_A = {(NP*RW){1'b1}};
  localparam logic [NP*RW-1:0] BMP_B = make_bmp();

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          display_on = 1'b0;
  logic [WX-1:0] pixel_x = 10'd5;
  logic [WY-1:0] pixel_y = 9'd5;
  logic [WX-1:0] sprite_x = '0;
  logic [WY-1:0] sprite_y = '0;
  logic          sprite_enable = 1'b0;
  logic          within_a, within_b, fh_a, fh_b;
  logic [RW-1:0] rgb_a, rgb_b;

  game_sprite_display dut_a (
    .clk(clk), .rst(rst), .display_on(display_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_enable(sprite_enable),
    .sprite_within(within_a), .sprite_rgb(rgb_a), .frame_hit(fh_a)
  );

  game_sprite_display #(.SPRITE_BITMAP(BMP_B)) dut_b (
    .clk(clk), .rst(rst), .display_on(display_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_enable(sprite_enable),
    .sprite_within(within_b), .sprite_rgb(rgb_b), .frame_hit(fh_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic          wa;
    logic [RW-1:0] ra;
    logic          wb;
    logic [RW-1:0] rb;
  } pix_exp_t;

  typedef struct {
    int   due;
    logic fa;
    logic fb;
  } fh_exp_t;

  pix_exp_t pq[$];
  fh_exp_t  fq[$];
  int total = 0;
  int bad   = 0;

  // Reference model state (whole-frame view of the behaviour).
  int m_sx, m_sy;
  bit m_en, m_active, m_prev00, m_acc_a, m_acc_b, m_fh_a, m_fh_b;
  // Requested sprite inputs; applied on the next driven pixel.
  int t_sx = 0, t_sy = 0;
  bit t_en = 1'b0;

  function automatic logic [RW-1:0] pix_of(input logic [NP*RW-1:0] b,
                                          input int c, input int r);
    logic [NP*RW-1:0] s;
    s = b >> ((r * SW + c) * RW);
    return s[RW-1:0];
  endfunction

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d", name, act, want, cyc);
    end
  endtask

  // Monitor: pops expectations when they fall due and compares outputs.
  pix_exp_t me;
  fh_exp_t  mf;
  always @(negedge clk) begin
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      me = pq.pop_front();
      if (me.due != cyc) chk("pix_sched", me.due, cyc);
      else begin
        chk("within_a", int'(within_a), int'(me.wa));
        chk("rgb_a",    int'(rgb_a),    int'(me.ra));
        chk("within_b", int'(within_b), int'(me.wb));
        chk("rgb_b",    int'(rgb_b),    int'(me.rb));
      end
    end
    while (fq.size() > 0 && fq[0].due <= cyc) begin
      mf = fq.pop_front();
      if (mf.due != cyc) chk("fh_sched", mf.due, cyc);
      else begin
        chk("frame_hit_a", int'(fh_a), int'(mf.fa));
        chk("frame_hit_b", int'(fh_b), int'(mf.fb));
      end
    end
  end

  // Drive one pixel per cycle and push what the model says should come out.
  task automatic drive(input int x, input int y, input bit d, input bit r);
    pix_exp_t e;
    fh_exp_t  f;
    bit fs, was;
    int dx, dy;
    logic [RW-1:0] pa, pb;
    @(posedge clk);
    #1;
    if (r && !rst) begin
      for (int i = 0; i < pq.size(); i++) begin
        pq[i].wa = 1'b0; pq[i].ra = '0; pq[i].wb = 1'b0; pq[i].rb = '0;
      end
      for (int i = 0; i < fq.size(); i++) begin
        fq[i].fa = 1'b0; fq[i].fb = 1'b0;
      end
    end
    rst = r;
    pixel_x = WX'(x);
    pixel_y = WY'(y);
    display_on = d;
    sprite_x = WX'(t_sx);
    sprite_y = WY'(t_sy);
    sprite_enable = t_en;
    pa = '0;
    pb = '0;
    if (r) begin
      m_sx = 0; m_sy = 0; m_en = 0; m_active = 0; m_prev00 = 0;
      m_acc_a = 0; m_acc_b = 0; m_fh_a = 0; m_fh_b = 0;
    end else begin
      fs = (x == 0 && y == 0) && !m_prev00;
      m_prev00 = (x == 0 && y == 0);
      was = m_active;
      if (fs) begin
        m_sx = t_sx; m_sy = t_sy; m_en = t_en;
        m_fh_a = m_acc_a; m_fh_b = m_acc_b;
        m_acc_a = 0; m_acc_b = 0;
        m_active = 1;
      end
      dx = x - m_sx;
      dy = y - m_sy;
      if (was && d && m_en && dx >= 0 && dx < SW && dy >= 0 && dy < SH) begin
        pa = pix_of(BMP_A, dx, dy);
        pb = pix_of(BMP_B, dx, dy);
      end
      m_acc_a = m_acc_a | (pa != 0);
      m_acc_b = m_acc_b | (pb != 0);
    end
    e.due = cyc + 2; e.wa = (pa != 0); e.ra = pa; e.wb = (pb != 0); e.rb = pb;
    pq.push_back(e);
    f.due = cyc + 1; f.fa = m_fh_a; f.fb = m_fh_b;
    fq.push_back(f);
  endtask

  // Blank tail of the previous frame, then the (0,0) pixel.
  task automatic new_frame();
    for (int i = 0; i < 3; i++) drive(639, 479, 1'b0, 1'b0);
    drive(0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    int x, y;
    // Reset, then sweep the top-left corner with no frame start.
    for (int i = 0; i < 3; i++) drive(5, 5, 1'b0, 1'b1);
    t_sx = 0; t_sy = 0; t_en = 1'b1;
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++)
        if (xx != 0 || yy != 0) drive(xx, yy, 1'b1, 1'b0);

    // Sprite at (100,50): edges and just-outside pixels.
    t_sx = 100; t_sy = 50; t_en = 1'b1;
    new_frame();
    drive(100, 50, 1, 0); drive(107, 57, 1, 0); drive(108, 50, 1, 0);
    drive(99, 50, 1, 0);  drive(100, 58, 1, 0); drive(101, 50, 1, 0);
    drive(103, 51, 1, 0); drive(105, 49, 1, 0);

    // Mid-frame move is ignored until the next frame start.
    t_sx = 200;
    drive(100, 50, 1, 0); drive(200, 50, 1, 0);
    new_frame();
    drive(200, 50, 1, 0); drive(100, 50, 1, 0); drive(207, 57, 1, 0);

    // display_on gating, then a disabled frame.
    t_sx = 100;
    new_frame();
    drive(100, 50, 0, 0); drive(100, 50, 1, 0);
    t_en = 1'b0;
    new_frame();
    drive(100, 50, 1, 0); drive(104, 53, 1, 0);
    t_en = 1'b1;
    new_frame();
    drive(102, 52, 1, 0);

    // Reset mid-frame: nothing drawn until a fresh frame start.
    drive(100, 50, 1, 0);
    drive(101, 50, 1, 1); drive(101, 50, 1, 1);
    drive(100, 50, 1, 0); drive(101, 51, 1, 0);
    new_frame();
    drive(100, 50, 1, 0); drive(101, 51, 1, 0);

    // Randomised frames, including sprites hugging the screen edges.
    for (int fr = 0; fr < 10; fr++) begin
      case ($urandom_range(0, 2))
        0: begin t_sx = $urandom_range(0, 5);     t_sy = $urandom_range(0, 5); end
        1: begin t_sx = $urandom_range(630, 639); t_sy = $urandom_range(470, 479); end
        default: begin t_sx = $urandom_range(0, 639); t_sy = $urandom_range(0, 479); end
      endcase
      t_en = ($urandom_range(0, 3) != 0);
      new_frame();
      for (int k = 0; k < 40; k++) begin
        x = m_sx + int'($urandom_range(0, 11)) - 2;
        y = m_sy + int'($urandom_range(0, 11)) - 2;
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
        if (x == 0 && y == 0) x = 1;
        if ($urandom_range(0, 9) == 0) t_sx = $urandom_range(0, 639);
        drive(x, y, ($urandom_range(0, 4) != 0), 1'b0);
      end
    end
    new_frame();
    for (int i = 0; i < 3; i++) drive(639, 479, 1'b0, 1'b0);

    // Let the scoreboard drain, bounded.
    for (int i = 0; i < 10; i++) begin
      if (pq.size() == 0 && fq.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    if (pq.size() != 0 || fq.size() != 0)
      chk("drain", pq.size() + fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_sprite_display.md
Name: game_sprite_display

Overview:
Downstream consumer of game_sprite_control. Takes the sprite's live sprite_x/sprite_y and the raster scan position from the display timing block, and produces a per-pixel sprite_within flag and colour for the pixel mixer. Coordinates are shadowed once per frame so a sprite never tears mid-frame. Also reports whether the sprite was visible anywhere in the previous frame, for game logic.

Parameters:
SPRITE_WIDTH, 8, sprite width in pixels
SPRITE_HEIGHT, 8, sprite height in pixels
screen_width, 640, active display width
screen_height, 480, active display height
w_x, $clog2(screen_width), x coordinate width
w_y, $clog2(screen_height), y coordinate width
RGB_WIDTH, 3, colour bits per pixel
SPRITE_BITMAP, {SPRITE_WIDTH*SPRITE_HEIGHT{3'b111}}, packed bitmap; pixel (col c, row r) = bits [(r*SPRITE_WIDTH+c)*RGB_WIDTH +: RGB_WIDTH]; value 0 = transparent

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
display_on  input  1  raster is in the active area
pixel_x  input  w_x  current raster x
pixel_y  input  w_y  current raster y
sprite_x  input  w_x  sprite top-left x, from game_sprite_control
sprite_y  input  w_y  sprite top-left y, from game_sprite_control
sprite_enable  input  1  show sprite this frame (sampled at frame start)
sprite_within  output  1  sprite covers the pixel, registered
sprite_rgb  output  RGB_WIDTH  sprite colour; 0 when sprite_within=0
frame_hit  output  1  sprite drew at least one pixel in the previous complete frame

Behaviour:
- Reset: sprite_within=0, sprite_rgb=0, frame_hit=0; shadow x/y/enable=0; hit accumulator=0; FSM=WAIT_FRAME; pipeline valid bits=0.
- Frame start (fs): the cycle where pixel_x==0 && pixel_y==0 and the previous cycle was not (0,0). Detection uses an internal previous-(0,0) register.
- FSM:
  - WAIT_FRAME -> ACTIVE on the first fs.
  - ACTIVE stays ACTIVE; only rst leaves it.
  - In WAIT_FRAME, stage-1 hit is forced to 0.
- At fs:
  - Shadow x/y/enable <= sprite_x/sprite_y/sprite_enable.
  - frame_hit <= hit_accum (zero on the first fs after reset); hit_accum <= 0.
  - The fs pixel itself is evaluated with the newly sampled values (bypass mux).
- Stage 1 (registered at N+1 for pixel presented at cycle N):
  - dx = pixel_x - shadow_x and dy = pixel_y - shadow_y, as (w+1)-bit signed.
  - hit1 = ACTIVE && display_on && shadow_enable && 0<=dx<SPRITE_WIDTH && 0<=dy<SPRITE_HEIGHT.
  - Register col=dx[$clog2(SPRITE_WIDTH)-1:0] and row likewise.
- Stage 2 (registered at N+2):
  - pix = bitmap lookup (col,row).
  - sprite_within = hit1 && pix!=0.
  - sprite_rgb = sprite_within ? pix : 0.
- Fixed latency exactly 2 cycles, every cycle, no stalls.
- hit_accum |= sprite_within each cycle (sticky until the next fs).
- Clipping:
  - Sprite extending past the right/bottom edge: off-screen pixels are never scanned; no wrap-around.
  - Subtraction is signed, so pixel_x < shadow_x never aliases to a hit.
- sprite_x/y changes mid-frame: ignored until the next fs.
- rst mid-frame: all outputs 0 from the reset edge; drawing resumes only after the next fs.

Decomposition:
- game_sprite_pkg: RGB_WIDTH default, transparent-colour constant (0), FSM state enum {WAIT_FRAME, ACTIVE}.
- Sub-module game_sprite_rom: combinational bitmap index (col,row)->pix, parameterised by size and bitmap. This keeps the ROM replaceable by block RAM later.

Test Plan:
1. Reset, sweep pixels (0..15,0..15) with display_on=1 and no fs -> sprite_within=0, sprite_rgb=0 throughout.
2. Setup: sprite_x=100, sprite_y=50, enable=1, fs.
   - (100,50) -> within=1, rgb=3'b111 exactly 2 cycles later.
   - (107,57) -> 1.
   - (108,50), (99,50), (100,58) -> 0.
3. After test 2's fs, change sprite_x to 200 mid-frame.
   - (100,50) still hits and (200,50) does not.
   - After the next fs, (200,50) hits.
4. Same setup as test 2:
   - display_on=0 at (100,50) -> 0.
   - Enable=0 sampled at fs -> no hits all frame.
5. Bitmap with pixel (0,0)=0, sprite at (100,50) -> (100,50) within=0, rgb=0; (101,50) within=1.
6. Frame timing:
   - Frame with hits -> frame_hit=1 after the following fs.
   - Next frame with enable=0 -> frame_hit=0 after the fs after it.
   - rst asserted mid-frame -> all outputs 0, no hit until a new fs.
